shared_data_memory: RTL and testbench
=====================================

Name: shared_data_memory

Overview:
- Word-addressed data memory shared by NUM_PORTS pipelined CPU cores; generalises the fixed two-CPU shared data memory, where port buses are concatenated.
- A round-robin arbiter grants one access per cycle and stalls the losing ports.
- Read data is registered: it returns one cycle after the grant with a per-port valid strobe.
- Sits between each core's EX/MEM stage outputs and its MEM/WB stage.

Parameters:
- NUM_PORTS, 2, number of requesting cores (1..8)
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 32, byte-address width per port
- DEPTH, 128, memory depth in words (power of two)

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset; asynchronous, active-high
- addr_i  in  NUM_PORTS*ADDR_WIDTH  byte addresses; port k is slice [(k+1)*ADDR_WIDTH-1 : k*ADDR_WIDTH]
- data_i  in  NUM_PORTS*DATA_WIDTH  write data, sliced the same way
- mem_read_i  in  NUM_PORTS  per-port read request
- mem_write_i  in  NUM_PORTS  per-port write request
- stall_o  out  NUM_PORTS  combinational; high = request not serviced this cycle, hold request
- data_o  out  NUM_PORTS*DATA_WIDTH  registered read data per port
- rvalid_o  out  NUM_PORTS  one-cycle pulse, data_o slice valid
- addr_err_o  out  NUM_PORTS  one-cycle pulse, granted access was out of range

Behaviour:
- Reset (asynchronous, rst_i=1):
  - all memory words = 0
  - data_o = 0, rvalid_o = 0, addr_err_o = 0
  - round-robin pointer = 0
  - stall_o follows the combinational rule below.
- Request: req[k] = mem_read_i[k] | mem_write_i[k].
  - If both read and write are high, the access is a write and no rvalid is produced.
- Arbitration is combinational:
  - grant = first requesting port scanning from pointer upward, wrapping modulo NUM_PORTS.
  - At most one grant per cycle.
- stall_o[k] = req[k] & ~grant[k]. A non-requesting port never stalls.
- Pointer update on each cycle with any grant: pointer <= granted index + 1 (mod NUM_PORTS). With no request, the pointer holds.
- Word index = addr[clog2(DEPTH)+1 : 2]. Bits [1:0] are ignored (aligned-word accesses only).
- Range check: an address >= DEPTH*4 is out of range.
  - Out-of-range write: discarded.
  - Out-of-range read: returns 0 with rvalid.
  - Either case pulses addr_err_o[k] the next cycle.
- Write: memory[idx] <= data_i slice at the edge ending the grant cycle.
- Read latency is 1:
  - Cycle after the grant: data_o[k] = memory[idx] (pre-edge contents) and rvalid_o[k] = 1.
  - data_o[k] otherwise holds its last value.
- Read-after-write: a read granted in the cycle after a write to the same word returns the new data.
- Stalled cores must hold addr/data/request stable until stall_o drops. The block does not latch stalled requests.
- Reset asserted mid-operation: in-flight rvalid is cancelled, pointer returns to 0, memory is cleared. Nothing is serviced while rst_i=1.
- NUM_PORTS=1: stall_o is always 0; the block is a plain registered-read memory.

Decomposition:
- Package shared_mem_pkg: clog2 function, WORD_BYTES=4 constant, index-width localparams.
- Sub-module rr_arbiter (parameter N):
  - inputs: req, pointer
  - outputs: one-hot grant, granted index, any_grant
  - The parent owns the pointer register and the memory array.

Test Plan:
- Reset, then port0 writes 0x0000002A to addr 0x10; port0 reads addr 0x10 next cycle -> rvalid_o[0] one cycle after the read grant, data_o[0]=42, stall_o=0 throughout.
- NUM_PORTS=2, both ports read simultaneously from reset (pointer 0) -> port0 granted, stall_o=2'b10; next cycle port1 granted, stall_o=0; each rvalid one cycle after its own grant.
- Both ports issue continuous requests for 6 cycles -> grants alternate 0,1,0,1,0,1 with no starvation.
- Port1 writes 7 to addr 0x20 in cycle n; port0 reads 0x20 in cycle n+1 -> data_o[0]=7.
- Port0 writes to addr 0x200 (DEPTH=128) -> addr_err_o[0] pulses, memory unchanged. Port0 reads 0x200 -> data_o[0]=0, rvalid_o[0]=1, addr_err_o[0]=1.
- Assert rst_i in the same cycle a read is granted -> rvalid_o stays 0, memory[any]=0, next grant after release goes to port0.

Source files
------------

// File: rtl/shared_data_memory_pkg.sv
// Shared constants and elaboration-time helpers for the shared data memory.
// Word size is fixed at four bytes; index widths are derived from the parameters.
package shared_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = 2;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Never return zero so single-entry indices still have a legal vector width.
  function automatic int idx_width(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

endpackage

// File: rtl/shared_data_memory_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above the
// pointer, wrapping modulo N. The caller owns and advances the pointer.
module rr_arbiter
  import shared_mem_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  // Scan from the pointer; the first hit latches and masks all later ports.
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {PW{1'b0}};
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      int   cand;
      logic hit;
      cand        = (int'(pointer) + i) % N;
      hit         = ~any_grant & req[cand];
      grant[cand] = grant[cand] | hit;
      grant_idx   = hit ? PW'(cand) : grant_idx;
      any_grant   = any_grant | hit;
    end
  end

endmodule

// File: rtl/shared_data_memory.sv
// Word-addressed data memory shared by NUM_PORTS cores through a round-robin
// arbiter; one access per cycle, registered read data with per-port strobes.
module shared_data_memory
  import shared_mem_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 128
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_PORTS-1:0]            mem_read_i,
  input  logic [NUM_PORTS-1:0]            mem_write_i,
  output logic [NUM_PORTS-1:0]            stall_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [NUM_PORTS-1:0]            addr_err_o
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int PTR_W = idx_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]                 req_s;
  logic [NUM_PORTS-1:0]                 grant_s;
  logic [PTR_W-1:0]                     gnt_idx_s;
  logic                                 any_grant_s;
  logic [PTR_W-1:0]                     ptr_r;
  logic [PTR_W-1:0]                     ptr_next_s;
  logic [ADDR_WIDTH-1:0]                gnt_addr_s;
  logic [DATA_WIDTH-1:0]                gnt_data_s;
  logic                                 gnt_wr_s;
  logic                                 gnt_rd_s;
  logic                                 in_range_s;
  logic [IDX_W-1:0]                     word_idx_s;
  logic [DATA_WIDTH-1:0]                rd_word_s;
  logic [DATA_WIDTH-1:0]                mem_r [DEPTH];
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_r;
  logic [NUM_PORTS-1:0]                 rvalid_r;
  logic [NUM_PORTS-1:0]                 addr_err_r;

  assign req_s = mem_read_i | mem_write_i;

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_arb (
    .req       (req_s),
    .pointer   (ptr_r),
    .grant     (grant_s),
    .grant_idx (gnt_idx_s),
    .any_grant (any_grant_s)
  );

  assign stall_o = req_s & ~grant_s;

  // One-hot mux of the granted port's bus; a write wins over a simultaneous read.
  always_comb begin
    gnt_addr_s = {ADDR_WIDTH{1'b0}};
    gnt_data_s = {DATA_WIDTH{1'b0}};
    gnt_wr_s   = 1'b0;
    gnt_rd_s   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      gnt_addr_s = gnt_addr_s | (addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_s[k]}});
      gnt_data_s = gnt_data_s | (data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[k]}});
      gnt_wr_s   = gnt_wr_s | (grant_s[k] & mem_write_i[k]);
      gnt_rd_s   = gnt_rd_s | (grant_s[k] & mem_read_i[k] & ~mem_write_i[k]);
    end
  end

  assign in_range_s = ((gnt_addr_s >> (IDX_W + WORD_SHIFT)) == {ADDR_WIDTH{1'b0}});
  assign word_idx_s = gnt_addr_s[IDX_W+WORD_SHIFT-1:WORD_SHIFT];
  assign rd_word_s  = in_range_s ? mem_r[word_idx_s] : {DATA_WIDTH{1'b0}};

  // Advance past the winner so it becomes lowest priority; hold when idle.
  always_comb begin
    ptr_next_s = ptr_r;
    if (any_grant_s) begin
      ptr_next_s = (gnt_idx_s == PTR_W'(NUM_PORTS - 1)) ? {PTR_W{1'b0}}
                                                         : gnt_idx_s + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      ptr_next_s = ptr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r <= {PTR_W{1'b0}};
    end else begin
      ptr_r <= ptr_next_s;
    end
  end

  // Storage array; out-of-range writes are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (gnt_wr_s && in_range_s) begin
      mem_r[word_idx_s] <= gnt_data_s;
    end
  end

  // Registered read data and per-port strobes, one cycle after the grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_r     <= {(NUM_PORTS*DATA_WIDTH){1'b0}};
      rvalid_r   <= {NUM_PORTS{1'b0}};
      addr_err_r <= {NUM_PORTS{1'b0}};
    end else begin
      rvalid_r   <= grant_s & {NUM_PORTS{gnt_rd_s}};
      addr_err_r <= grant_s & {NUM_PORTS{~in_range_s}};
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (grant_s[k] && gnt_rd_s) begin
          data_r[k] <= rd_word_s;
        end
      end
    end
  end

  assign data_o     = data_r;
  assign rvalid_o   = rvalid_r;
  assign addr_err_o = addr_err_r;

endmodule

// File: tb/tb_shared_data_memory.sv
// Self-checking bench for shared_data_memory (two ports, 128 words): vector
// table plus reference model feeding a response scoreboard.
module tb_shared_data_memory;

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  stall;
  } vec_t;

  typedef struct {
    logic [1:0]  rvalid;
    logic [1:0]  err;
    logic [63:0] data;
  } resp_t;

  logic        clk;
  logic        rst;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  rd;
  logic [1:0]  wr;
  logic [1:0]  stall;
  logic [63:0] rdata;
  logic [1:0]  rvalid;
  logic [1:0]  aerr;

  int          nerr;
  int          nchecks;
  resp_t       sbq[$];
  logic [31:0] mmem [128];
  logic [31:0] mhold [2];
  int          mptr;
  vec_t        vt [23];

  shared_data_memory #(
    .NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(128)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .addr_i      (addr),
    .data_i      (wdata),
    .mem_read_i  (rd),
    .mem_write_i (wr),
    .stall_o     (stall),
    .data_o      (rdata),
    .rvalid_o    (rvalid),
    .addr_err_o  (aerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] s);
    vec_t v;
    v.rd = r; v.wr = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.stall = s;
    return v;
  endfunction

  task automatic model_reset();
    mptr = 0;
    for (int i = 0; i < 128; i++) mmem[i] = 32'h0;
    mhold[0] = 32'h0;
    mhold[1] = 32'h0;
    sbq.delete();
  endtask

  // Drive one cycle: check stall against the table, predict via the model, compare after the edge.
  task automatic apply(input string tag, input vec_t v);
    resp_t       e;
    logic [1:0]  req;
    int          g;
    logic [31:0] a;
    logic [31:0] d;
    rd    = v.rd;
    wr    = v.wr;
    addr  = {v.a1, v.a0};
    wdata = {v.d1, v.d0};
    #1;
    check({tag, " stall"}, {62'h0, stall}, {62'h0, v.stall});
    req = v.rd | v.wr;
    g = -1;
    for (int i = 0; i < 2; i++) begin
      int p;
      p = (mptr + i) % 2;
      if (g < 0 && req[p]) g = p;
    end
    e.rvalid = 2'b00;
    e.err    = 2'b00;
    if (g >= 0) begin
      a    = (g == 0) ? v.a0 : v.a1;
      d    = (g == 0) ? v.d0 : v.d1;
      mptr = (g + 1) % 2;
      if (a >= 32'h200) e.err[g] = 1'b1;
      if (v.wr[g]) begin
        if (a < 32'h200) mmem[a[8:2]] = d;
      end else begin
        e.rvalid[g] = 1'b1;
        mhold[g] = (a < 32'h200) ? mmem[a[8:2]] : 32'h0;
      end
    end
    e.data = {mhold[1], mhold[0]};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check({tag, " rvalid"}, {62'h0, rvalid}, {62'h0, e.rvalid});
    check({tag, " addr_err"}, {62'h0, aerr}, {62'h0, e.err});
    check({tag, " data"}, rdata, e.data);
  endtask

  task automatic idle_inputs();
    rd = 2'b00; wr = 2'b00; addr = 64'h0; wdata = 64'h0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  localparam logic [31:0] VA = 32'hAAAA_0001;
  localparam logic [31:0] VB = 32'hBBBB_0002;

  initial begin
    nerr = 0;
    nchecks = 0;
    vt[0]  = mk(2'b00, 2'b01, 32'h10,  32'h0,   32'h2A,    32'h0,  2'b00);
    vt[1]  = mk(2'b01, 2'b00, 32'h10,  32'h0,   32'h0,     32'h0,  2'b00);
    vt[2]  = mk(2'b11, 2'b00, 32'h10,  32'h10,  32'h0,     32'h0,  2'b01);
    vt[3]  = mk(2'b01, 2'b00, 32'h10,  32'h0,   32'h0,     32'h0,  2'b00);
    vt[4]  = mk(2'b00, 2'b11, 32'h30,  32'h34,  VA,        VB,     2'b01);
    vt[5]  = mk(2'b00, 2'b11, 32'h30,  32'h34,  VA,        VB,     2'b10);
    vt[6]  = mk(2'b00, 2'b11, 32'h30,  32'h34,  VA,        VB,     2'b01);
    vt[7]  = mk(2'b00, 2'b11, 32'h30,  32'h34,  VA,        VB,     2'b10);
    vt[8]  = mk(2'b00, 2'b11, 32'h30,  32'h34,  VA,        VB,     2'b01);
    vt[9]  = mk(2'b00, 2'b11, 32'h30,  32'h34,  VA,        VB,     2'b10);
    vt[10] = mk(2'b00, 2'b10, 32'h0,   32'h20,  32'h0,     32'h7,  2'b00);
    vt[11] = mk(2'b01, 2'b00, 32'h20,  32'h0,   32'h0,     32'h0,  2'b00);
    vt[12] = mk(2'b00, 2'b01, 32'h200, 32'h0,   32'hDEAD,  32'h0,  2'b00);
    vt[13] = mk(2'b01, 2'b00, 32'h200, 32'h0,   32'h0,     32'h0,  2'b00);
    vt[14] = mk(2'b10, 2'b00, 32'h0,   32'h30,  32'h0,     32'h0,  2'b00);
    vt[15] = mk(2'b10, 2'b00, 32'h0,   32'h34,  32'h0,     32'h0,  2'b00);
    vt[16] = mk(2'b01, 2'b01, 32'h40,  32'h0,   32'h55,    32'h0,  2'b00);
    vt[17] = mk(2'b01, 2'b00, 32'h40,  32'h0,   32'h0,     32'h0,  2'b00);
    vt[18] = mk(2'b00, 2'b00, 32'h0,   32'h0,   32'h0,     32'h0,  2'b00);
    vt[19] = mk(2'b10, 2'b00, 32'h0,   32'h43,  32'h0,     32'h0,  2'b00);
    vt[20] = mk(2'b10, 2'b01, 32'h1FC, 32'h1FC, 32'h99,    32'h0,  2'b10);
    vt[21] = mk(2'b10, 2'b01, 32'h1FC, 32'h1FC, 32'h99,    32'h0,  2'b01);
    vt[22] = mk(2'b01, 2'b00, 32'h0,   32'h0,   32'h0,     32'h0,  2'b00);

    // Power-on reset; stall must still follow the request/grant rule.
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset data_o", rdata, 64'h0);
    check("reset rvalid", {62'h0, rvalid}, 64'h0);
    check("reset addr_err", {62'h0, aerr}, 64'h0);
    check("reset stall idle", {62'h0, stall}, 64'h0);
    rd = 2'b11;
    #1;
    check("reset stall both", {62'h0, stall}, {62'h0, 2'b10});
    idle_inputs();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("no service during reset", {62'h0, rvalid}, 64'h0);

    for (int i = 0; i < 23; i++) begin
      apply($sformatf("vec%0d", i), vt[i]);
    end

    // Both ports read straight out of reset: port0 first, then port1; memory was cleared.
    reset_dut();
    apply("fresh both", mk(2'b11, 2'b00, 32'h10, 32'h1FC, 32'h0, 32'h0, 2'b10));
    apply("fresh p1",   mk(2'b10, 2'b00, 32'h10, 32'h1FC, 32'h0, 32'h0, 2'b00));

    // Reset asserted while a read is being granted.
    apply("pre write", mk(2'b00, 2'b10, 32'h0, 32'h34, 32'h0, 32'hBEEF, 2'b00));
    rd = 2'b01; wr = 2'b00; addr = {32'h0, 32'h34};
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst rvalid", {62'h0, rvalid}, 64'h0);
    check("midrst data", rdata, 64'h0);
    idle_inputs();
    rst = 1'b0;
    model_reset();
    apply("post rst both", mk(2'b11, 2'b00, 32'h34, 32'h34, 32'h0, 32'h0, 2'b10));
    apply("post rst p1",   mk(2'b10, 2'b00, 32'h34, 32'h34, 32'h0, 32'h0, 2'b00));
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
